leds7_cmd_encoder: RTL

LEDS7_CMD_ENCODER -- requirements
Module: leds7_cmd_encoder

---
 rtl/leds7_cmd_encoder_pkg.sv | 27 ++
 rtl/leds7_cmd_encoder_if.sv | 28 ++
 rtl/leds7_cmd_encoder_rr_arbiter.sv | 51 +++++
 rtl/leds7_cmd_encoder.sv | 133 +++++++++++++
 4 files changed

// File: rtl/leds7_cmd_encoder_pkg.sv
// ============================================================================
// Module : Leds_7_pkg
// Brief  : Shared constants, encoder state type and header helper for the
//          7-segment command encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package Leds_7_pkg;

    localparam int         NUM_LEDS     = 4;
    localparam int         IDX_W        = $clog2(NUM_LEDS);
    localparam logic [7:0] LED_HDR_BASE = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_NUMB = 2'd1,
        ST_SEND_DATA = 2'd2
    } enc_state_t;

    function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] idx);
        return LED_HDR_BASE + {{(8-IDX_W){1'b0}}, idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/leds7_cmd_encoder_if.sv
// ============================================================================
// Module : leds7_cmd_encoder_if
// Brief  : Byte-stream valid/ready link from the encoder to a UART transmitter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface leds7_cmd_encoder_if;

    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;

    modport master (
        output uart_tx_data,
        output uart_tx_valid,
        input  uart_tx_ready
    );

    modport slave (
        input  uart_tx_data,
        input  uart_tx_valid,
        output uart_tx_ready
    );

endinterface

`default_nettype wire

// File: rtl/leds7_cmd_encoder_rr_arbiter.sv
// ============================================================================
// Module : leds7_rr_arbiter
// Brief  : Round-robin arbiter over the digit requests; the search starts one
//          past the last accepted grant.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leds7_rr_arbiter
    import Leds_7_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 resetn,
    input  wire logic [NUM_LEDS-1:0]  i_req,
    input  wire logic                 i_accept,
    output logic      [NUM_LEDS-1:0]  o_grant,
    output logic      [IDX_W-1:0]     o_grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_cand  = r_ptr;
        w_idx   = r_ptr;
        w_found = 1'b0;
        o_grant = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            w_cand = r_ptr + IDX_W'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        o_grant[w_idx] = w_found;
        o_grant_idx    = w_idx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= w_idx + IDX_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/leds7_cmd_encoder.sv
// ============================================================================
// Module : leds7_cmd_encoder
// Brief  : Turns per-digit update strobes into header/data byte pairs for a
//          UART. Optional periodic full refresh with LEDS7_CMD_PERIODIC_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leds7_cmd_encoder
    import Leds_7_pkg::*;
#(
    parameter int REFRESH_PERIOD = 50_000_000
) (
    input  wire logic                          clk,
    input  wire logic                          resetn,
    input  wire logic [NUM_LEDS-1:0][3:0]      digit_data,
    input  wire logic [NUM_LEDS-1:0]           digit_update,
    leds7_cmd_encoder_if.master                tx,
    output logic                               busy
);

    enc_state_t                 r_state;
    enc_state_t                 w_next_state;
    logic [NUM_LEDS-1:0]        r_pending;
    logic [NUM_LEDS-1:0][3:0]   r_shadow;
    logic [IDX_W-1:0]           r_tx_idx;
    logic [3:0]                 r_tx_val;
    logic [NUM_LEDS-1:0]        w_grant;
    logic [IDX_W-1:0]           w_grant_idx;
    logic                       w_accept;
    logic                       w_refresh;

    assign w_accept = (r_state == ST_IDLE) && (|r_pending);
    assign busy     = (|r_pending) || (r_state != ST_IDLE);

    leds7_rr_arbiter u_arb (
        .clk         (clk),
        .resetn      (resetn),
        .i_req       (r_pending),
        .i_accept    (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

`ifdef LEDS7_CMD_PERIODIC_EN
    localparam int c_cnt_w = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    logic [c_cnt_w-1:0] r_refresh_cnt;

    assign w_refresh = (r_refresh_cnt == c_cnt_w'(REFRESH_PERIOD - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_refresh_cnt <= '0;
        end else if (w_refresh) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + c_cnt_w'(1);
        end
    end
`else
    // Refresh disabled; the parameter only matters in the periodic build.
    assign w_refresh = 1'b0 && (REFRESH_PERIOD != 0);
`endif

    // A new strobe (or refresh) outranks the clear from the grant in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= '0;
            r_shadow  <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (digit_update[i]) begin
                    r_shadow[i]  <= digit_data[i];
                    r_pending[i] <= 1'b1;
                end else if (w_refresh) begin
                    r_pending[i] <= 1'b1;
                end else if (w_accept && w_grant[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_idx <= '0;
            r_tx_val <= '0;
        end else if (w_accept) begin
            r_tx_idx <= w_grant_idx;
            r_tx_val <= r_shadow[w_grant_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (|r_pending)        w_next_state = ST_SEND_NUMB;
            ST_SEND_NUMB: if (tx.uart_tx_ready)  w_next_state = ST_SEND_DATA;
            ST_SEND_DATA: if (tx.uart_tx_ready)  w_next_state = ST_IDLE;
            default:                             w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        tx.uart_tx_valid = 1'b0;
        tx.uart_tx_data  = 8'h00;
        case (r_state)
            ST_SEND_NUMB: begin
                tx.uart_tx_valid = 1'b1;
                tx.uart_tx_data  = hdr_byte(r_tx_idx);
            end
            ST_SEND_DATA: begin
                tx.uart_tx_valid = 1'b1;
                tx.uart_tx_data  = {4'h0, r_tx_val};
            end
            default: begin
                tx.uart_tx_valid = 1'b0;
                tx.uart_tx_data  = 8'h00;
            end
        endcase
    end

endmodule

`default_nettype wire
